// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    AACK,
    WBYTE,
    WACK,
    RBYTE,
    RACK,
    IGNORE
  } i2c_tstate_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Bus line conditioning: 2-flop synchroniser, optional majority-free glitch
// filter (I2C_TARGET_FILTER_EN), then rise/fall pulse generation.
// Without the macro the filtered level is the synchronised line.
module i2c_line_filter #(
  parameter int FILTLEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line_raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       level_q;

  // Two-flop synchroniser, preset high to match an idle bus.
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], line_raw};
  end

`ifdef I2C_TARGET_FILTER_EN
  logic [FILTLEN-2:0] hist;
  logic [FILTLEN-1:0] window;
  logic               filt;

  assign window = {hist, sync[1]};

  // Level only moves once FILTLEN consecutive samples agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '1;
      filt <= 1'b1;
    end else begin
      hist <= window[FILTLEN-2:0];
      if (&window)      filt <= 1'b1;
      else if (~|window) filt <= 1'b0;
    end
  end

  assign level = filt;
`else
  assign level = sync[1];
`endif

  // Previous level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b1;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target with an 8-bit auto-incrementing pointer register-file port.
// Optional glitch filter on SCL/SDA: define I2C_TARGET_FILTER_EN.
//
// state  | meaning
// IDLE   | bus free, waiting for START
// ADDR   | shifting in address + R/W
// AACK   | own address matched, driving ACK on 9th clock
// WBYTE  | shifting in a write byte (pointer or data)
// WACK   | driving ACK for a received write byte
// RBYTE  | shifting out a read byte
// RACK   | sampling controller ACK/NACK after a read byte
// IGNORE | not for us or read ended, released until START/STOP
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TADDR   = 7'h50,
  parameter int         TXHOLD  = 4,
  parameter int         FILTLEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sdarx,
  output logic       sdatx,
  output logic       sdaasrx,
  output logic [7:0] regaddr,
  output logic [7:0] wdata,
  output logic       wstb,
  input  logic [7:0] rdata,
  output logic       rstb,
  output logic       busy,
  output logic       addressed
);

  localparam int HW = (TXHOLD > 1) ? $clog2(TXHOLD) : 1;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_line_filter #(.FILTLEN(FILTLEN)) u_scl (
    .clk(clk), .rst(rst), .line_raw(scl),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILTLEN(FILTLEN)) u_sda (
    .clk(clk), .rst(rst), .line_raw(sdarx),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign sdatx     = 1'b0;

  i2c_tstate_t state, state_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic [7:0]    shreg, shreg_n, byte_in;
  logic [7:0]    regaddr_n, wdata_n;
  logic          wstb_n, rstb_n, busy_n, addressed_n;
  logic          first, first_n, rw, rw_n;
  logic          sdaasrx_n, tx_bit, tx_bit_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic          sched, sched_val;

  // State and datapath registers; reset releases SDA immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      regaddr   <= '0;
      wdata     <= '0;
      wstb      <= 1'b0;
      rstb      <= 1'b0;
      busy      <= 1'b0;
      addressed <= 1'b0;
      first     <= 1'b0;
      rw        <= 1'b0;
      sdaasrx   <= 1'b1;
      tx_bit    <= 1'b1;
      hold_cnt  <= '0;
    end else begin
      state     <= state_n;
      bitcnt    <= bitcnt_n;
      shreg     <= shreg_n;
      regaddr   <= regaddr_n;
      wdata     <= wdata_n;
      wstb      <= wstb_n;
      rstb      <= rstb_n;
      busy      <= busy_n;
      addressed <= addressed_n;
      first     <= first_n;
      rw        <= rw_n;
      sdaasrx   <= sdaasrx_n;
      tx_bit    <= tx_bit_n;
      hold_cnt  <= hold_cnt_n;
    end
  end

  // Next-state logic: START/STOP first, then per-state bit handling.
  always_comb begin
    state_n     = state;
    bitcnt_n    = bitcnt;
    shreg_n     = shreg;
    regaddr_n   = regaddr;
    wdata_n     = wdata;
    wstb_n      = 1'b0;
    rstb_n      = 1'b0;
    busy_n      = busy;
    addressed_n = addressed;
    first_n     = first;
    rw_n        = rw;
    sdaasrx_n   = sdaasrx;
    tx_bit_n    = tx_bit;
    hold_cnt_n  = hold_cnt;
    sched       = 1'b0;
    sched_val   = 1'b1;
    byte_in     = {shreg[6:0], sda_lvl};

    // pointer advances the cycle after a data write strobe
    if (wstb) regaddr_n = regaddr + 8'd1;

    // SDA hold timer: apply the pending bit at terminal count
    if (hold_cnt != '0) begin
      hold_cnt_n = hold_cnt - HW'(1);
      if (hold_cnt == HW'(1)) sdaasrx_n = tx_bit;
    end

    if (start_det) begin
      state_n     = ADDR;
      bitcnt_n    = '0;
      busy_n      = 1'b1;
      addressed_n = 1'b0;
      sdaasrx_n   = 1'b1;
      hold_cnt_n  = '0;
    end else if (stop_det) begin
      state_n     = IDLE;
      busy_n      = 1'b0;
      addressed_n = 1'b0;
      sdaasrx_n   = 1'b1;
      hold_cnt_n  = '0;
    end else begin
      unique case (state)
        ADDR: begin
          if (scl_rise) begin
            shreg_n  = byte_in;
            bitcnt_n = bitcnt + 4'd1;
            if (bitcnt == 4'd7) begin
              if (byte_in[7:1] == TADDR) begin
                state_n     = AACK;
                addressed_n = 1'b1;
                rw_n        = byte_in[0];
              end else begin
                state_n = IGNORE;
              end
            end
          end
        end
        AACK: begin
          if (scl_fall && bitcnt == 4'd8) begin
            sched     = 1'b1;
            sched_val = I2C_ACK;
          end else if (scl_rise) begin
            bitcnt_n = 4'd9;
          end else if (scl_fall) begin
            bitcnt_n = '0;
            sched    = 1'b1;
            if (!rw) begin
              state_n   = WBYTE;
              first_n   = 1'b1;
              sched_val = 1'b1;
            end else begin
              state_n   = RBYTE;
              rstb_n    = 1'b1;
              shreg_n   = rdata;
              sched_val = rdata[7];
            end
          end
        end
        WBYTE: begin
          if (scl_rise) begin
            shreg_n  = byte_in;
            bitcnt_n = bitcnt + 4'd1;
            if (bitcnt == 4'd7) begin
              state_n = WACK;
              if (first) begin
                regaddr_n = byte_in;
                first_n   = 1'b0;
              end else begin
                wdata_n = byte_in;
                wstb_n  = 1'b1;
              end
            end
          end
        end
        WACK: begin
          if (scl_fall && bitcnt == 4'd8) begin
            sched     = 1'b1;
            sched_val = I2C_ACK;
          end else if (scl_rise) begin
            bitcnt_n = 4'd9;
          end else if (scl_fall) begin
            state_n   = WBYTE;
            bitcnt_n  = '0;
            sched     = 1'b1;
            sched_val = 1'b1;
          end
        end
        RBYTE: begin
          if (scl_rise) begin
            bitcnt_n = bitcnt + 4'd1;
          end else if (scl_fall) begin
            sched = 1'b1;
            if (bitcnt == 4'd8) begin
              state_n   = RACK;
              sched_val = 1'b1;
            end else begin
              sched_val = shreg[6];
              shreg_n   = {shreg[6:0], 1'b0};
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            if (sda_lvl == I2C_ACK) begin
              regaddr_n = regaddr + 8'd1;
              bitcnt_n  = 4'd9;
            end else begin
              state_n = IGNORE;
            end
          end else if (scl_fall && bitcnt == 4'd9) begin
            state_n   = RBYTE;
            bitcnt_n  = '0;
            rstb_n    = 1'b1;
            shreg_n   = rdata;
            sched     = 1'b1;
            sched_val = rdata[7];
          end
        end
        IDLE, IGNORE: ;
        default: state_n = IDLE;
      endcase
    end

    // schedule the SDA change TXHOLD cycles after the SCL fall
    if (sched) begin
      if (TXHOLD == 1) begin
        sdaasrx_n  = sched_val;
        hold_cnt_n = '0;
      end else begin
        hold_cnt_n = HW'(TXHOLD - 1);
        tx_bit_n   = sched_val;
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: bit-banged controller on a wired-AND
// bus, write scoreboard on wstb, read-byte scoreboard on the bus side.
module tb_i2c_target;

  localparam int Q = 20;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] fin;
  } wvec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda, sda_bus;
  logic       sdatx, sdaasrx, wstb, rstb, busy, addressed;
  logic [7:0] regaddr, wdata, rdata;

  int checks = 0;
  int errors = 0;
  int rstb_cnt = 0;
  int both_viol = 0;
  int tx_viol = 0;
  int rel_viol = 0;
  logic chk_release = 1'b0;

  wr_t        exp_wq[$];
  logic [7:0] exp_rq[$];
  wr_t        exp_w;
  wvec_t      wtab[3];
  logic       ack;
  logic [7:0] d, e, gb;

  always #5 clk = ~clk;

  assign sda_bus = m_sda & (sdaasrx | sdatx);
  assign rdata   = regaddr ^ 8'hFF;

  i2c_target #(.TADDR(7'h50), .TXHOLD(4), .FILTLEN(3)) dut (
    .clk(clk), .rst(rst), .scl(m_scl), .sdarx(sda_bus),
    .sdatx(sdatx), .sdaasrx(sdaasrx), .regaddr(regaddr), .wdata(wdata),
    .wstb(wstb), .rdata(rdata), .rstb(rstb), .busy(busy), .addressed(addressed)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write scoreboard and invariant monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (wstb) begin
        if (exp_wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wstb_unexpected: addr %0h data %0h with none expected", regaddr, wdata);
        end else begin
          exp_w = exp_wq.pop_front();
          check("wstb_addr", regaddr, exp_w.addr);
          check("wstb_data", wdata, exp_w.data);
        end
      end
      if (rstb) rstb_cnt++;
      if (wstb && rstb) both_viol++;
      if (chk_release && sdaasrx !== 1'b1) rel_viol++;
    end
    if (sdatx !== 1'b0) tx_viol++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_start();
    m_sda = 1'b1; m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic rep_start();
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic send_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(Q);
  endtask

  task automatic write_bits(input logic [7:0] b, input int n, input int glitch_bit);
    for (int i = 7; i > 7 - n; i--) begin
      m_sda = b[i]; wait_clk(Q);
      m_scl = 1'b1;
      if (i == glitch_bit) begin
        wait_clk(5); m_scl = 1'b0; wait_clk(2); m_scl = 1'b1; wait_clk(Q - 7);
      end else begin
        wait_clk(Q);
      end
      wait_clk(Q);
      m_scl = 1'b0; wait_clk(Q);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic a);
    write_bits(b, 8, glitch_bit);
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    a = sda_bus; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] v);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_clk(Q);
      m_scl = 1'b1; wait_clk(Q);
      v[i] = sda_bus; wait_clk(Q);
      m_scl = 1'b0;
    end
    wait_clk(Q / 2);
    m_sda = mack; wait_clk(Q / 2);
    m_scl = 1'b1; wait_clk(2 * Q);
    m_scl = 1'b0; wait_clk(Q);
    m_sda = 1'b1;
  endtask

  initial begin
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    wait_clk(5);
    check("rst_sdaasrx", sdaasrx, 1'b1);
    check("rst_sdatx", sdatx, 1'b0);
    check("rst_regaddr", regaddr, 8'h00);
    check("rst_wdata", wdata, 8'h00);
    check("rst_wstb", wstb, 1'b0);
    check("rst_rstb", rstb, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_addressed", addressed, 1'b0);
    rst = 1'b0;
    wait_clk(5);

    // pointer write followed by two data bytes, including pointer wrap
    wtab[0] = '{ptr: 8'h10, d0: 8'hA5, d1: 8'h5A, fin: 8'h12};
    wtab[1] = '{ptr: 8'hFF, d0: 8'h33, d1: 8'hC4, fin: 8'h01};
    wtab[2] = '{ptr: 8'h7E, d0: 8'h00, d1: 8'hFF, fin: 8'h80};
    for (int k = 0; k < 3; k++) begin
      exp_wq.push_back('{addr: wtab[k].ptr, data: wtab[k].d0});
      exp_wq.push_back('{addr: wtab[k].ptr + 8'd1, data: wtab[k].d1});
      send_start();
      check("wr_busy", busy, 1'b1);
      write_byte(8'hA0, -1, ack); check("wr_addr_ack", ack, 1'b0);
      check("wr_addressed", addressed, 1'b1);
      write_byte(wtab[k].ptr, -1, ack); check("wr_ptr_ack", ack, 1'b0);
      write_byte(wtab[k].d0, -1, ack);  check("wr_d0_ack", ack, 1'b0);
      write_byte(wtab[k].d1, -1, ack);  check("wr_d1_ack", ack, 1'b0);
      check("wr_final_regaddr", regaddr, wtab[k].fin);
      send_stop();
      check("wr_busy_after_stop", busy, 1'b0);
      check("wr_addressed_after_stop", addressed, 1'b0);
      check("wr_queue_drained", exp_wq.size(), 0);
    end

    // read: pointer 0x20, repeated START, two bytes (ACK then NACK)
    rstb_cnt = 0;
    exp_rq.push_back(8'h20 ^ 8'hFF);
    exp_rq.push_back(8'h21 ^ 8'hFF);
    send_start();
    write_byte(8'hA0, -1, ack); check("rd_waddr_ack", ack, 1'b0);
    write_byte(8'h20, -1, ack); check("rd_ptr_ack", ack, 1'b0);
    rep_start();
    write_byte(8'hA1, -1, ack); check("rd_raddr_ack", ack, 1'b0);
    check("rd_addressed", addressed, 1'b1);
    read_byte(1'b0, d); e = exp_rq.pop_front(); check("rd_byte0", d, e);
    read_byte(1'b1, d); e = exp_rq.pop_front(); check("rd_byte1", d, e);
    check("rd_regaddr", regaddr, 8'h21);
    check("rd_rstb_count", rstb_cnt, 2);
    check("rd_busy_before_stop", busy, 1'b1);
    send_stop();
    check("rd_busy_after_stop", busy, 1'b0);

    // address mismatch: NACK, stays released, no strobes
    rstb_cnt = 0;
    send_start();
    chk_release = 1'b1;
    write_byte(8'hA2, -1, ack); check("mm_nack", ack, 1'b1);
    check("mm_addressed", addressed, 1'b0);
    write_byte(8'h00, -1, ack); check("mm_data_nack", ack, 1'b1);
    send_stop();
    chk_release = 1'b0;
    check("mm_release_violations", rel_viol, 0);
    check("mm_rstb_count", rstb_cnt, 0);
    check("mm_busy", busy, 1'b0);

    // STOP after 4 data bits: partial byte discarded
    send_start();
    write_byte(8'hA0, -1, ack); check("ab_addr_ack", ack, 1'b0);
    write_byte(8'h40, -1, ack); check("ab_ptr_ack", ack, 1'b0);
    write_bits(8'hC0, 4, -1);
    send_stop();
    check("ab_regaddr", regaddr, 8'h40);
    check("ab_busy", busy, 1'b0);
    exp_wq.push_back('{addr: 8'h40, data: 8'h99});
    send_start();
    write_byte(8'hA0, -1, ack); check("ab2_addr_ack", ack, 1'b0);
    write_byte(8'h40, -1, ack); check("ab2_ptr_ack", ack, 1'b0);
    write_byte(8'h99, -1, ack); check("ab2_data_ack", ack, 1'b0);
    send_stop();
    check("ab2_regaddr", regaddr, 8'h41);

    // 2-clk SCL low glitch during the first data bit
    gb = 8'hB5;
`ifdef I2C_TARGET_FILTER_EN
    exp_wq.push_back('{addr: 8'h30, data: gb});
`else
    exp_wq.push_back('{addr: 8'h30, data: {gb[7], gb[7:1]}});
`endif
    send_start();
    write_byte(8'hA0, -1, ack); check("gl_addr_ack", ack, 1'b0);
    write_byte(8'h30, -1, ack); check("gl_ptr_ack", ack, 1'b0);
    write_byte(gb, 7, ack);
    send_stop();
    check("gl_regaddr", regaddr, 8'h31);
    check("gl_queue_drained", exp_wq.size(), 0);

    // reset while the target drives a 0 data bit
    send_start();
    write_byte(8'hA0, -1, ack); check("rr_waddr_ack", ack, 1'b0);
    write_byte(8'h80, -1, ack); check("rr_ptr_ack", ack, 1'b0);
    rep_start();
    write_byte(8'hA1, -1, ack); check("rr_raddr_ack", ack, 1'b0);
    check("rr_driving_low", sdaasrx, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rr_sdaasrx_next_cycle", sdaasrx, 1'b1);
    check("rr_regaddr", regaddr, 8'h00);
    check("rr_wdata", wdata, 8'h00);
    check("rr_strobes", {wstb, rstb}, 2'b00);
    check("rr_busy_addressed", {busy, addressed}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    m_sda = 1'b1; m_scl = 1'b1;
    wait_clk(Q);
    check("rr_idle_busy", busy, 1'b0);
    check("rr_idle_release", sdaasrx, 1'b1);

    check("never_wstb_with_rstb", both_viol, 0);
    check("sdatx_always_zero", tx_viol, 0);
    check("write_queue_empty", exp_wq.size(), 0);
    check("read_queue_empty", exp_rq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
